// File: rtl/cpu_run_ctrl.sv
// Run controller for cpu_top: sequences core reset, watches retire/store buses,
// and latches how and when the run ended (tohost store, PC self-loop, or timeout).
//
// state  | meaning
// RESET  | core held in reset, hold counter running
// RUN    | core released, counters and termination checks active
// PASS   | tohost store of 1 seen
// FAIL   | tohost store of a non-zero, non-one value seen
// HALT   | PC self-loop or cycle timeout
module cpu_run_ctrl #(
  parameter int              XLEN         = 32,
  parameter int              CNT_W        = 32,
  parameter int              RESET_CYCLES = 2,
  parameter int              MAX_CYCLES   = 850,
  parameter logic [XLEN-1:0] TOHOST_ADDR  = 32'h0000_1000,
  parameter int              LOOP_LIMIT   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pc_addr,
  input  logic             we_regs,
  input  logic [4:0]       w_regs_addr,
  input  logic [XLEN-1:0]  w_regs_data,
  input  logic             mem_we,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic [XLEN-1:0]  mem_wdata,
  output logic             core_rst,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic [1:0]       status,
  output logic [XLEN-1:0]  fail_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count,
  output logic [XLEN-1:0]  gp_value
);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_RUN   = 3'd1,
    S_PASS  = 3'd2,
    S_FAIL  = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  localparam int               LW        = $clog2(LOOP_LIMIT + 1);
  localparam logic [7:0]       HOLD_LAST = 8'(RESET_CYCLES - 1);
  localparam logic [7:0]       HOLD_ONE  = 8'd1;
  localparam logic [LW-1:0]    LOOP_LAST = LW'(LOOP_LIMIT - 2);
  localparam logic [LW-1:0]    LOOP_ONE  = LW'(1);
  localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [XLEN-1:0]  DATA_ONE  = XLEN'(1);

  state_e           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic [LW-1:0]    loop_q, loop_d;
  logic [XLEN-1:0]  prev_pc_q, prev_pc_d;
  logic [1:0]       status_q, status_d;
  logic [XLEN-1:0]  fail_code_q, fail_code_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic [XLEN-1:0]  gp_q, gp_d;

  logic pc_same;
  logic tohost_hit;

  assign pc_same    = (pc_addr == prev_pc_q);
  assign tohost_hit = mem_we && (mem_addr == TOHOST_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RESET;
      hold_q      <= '0;
      loop_q      <= '0;
      prev_pc_q   <= '0;
      status_q    <= '0;
      fail_code_q <= '0;
      cycle_q     <= '0;
      retire_q    <= '0;
      gp_q        <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      loop_q      <= loop_d;
      prev_pc_q   <= prev_pc_d;
      status_q    <= status_d;
      fail_code_q <= fail_code_d;
      cycle_q     <= cycle_d;
      retire_q    <= retire_d;
      gp_q        <= gp_d;
    end
  end

  // Counters and monitors only move in RUN; terminal states freeze everything.
  always_comb begin
    hold_d    = hold_q;
    loop_d    = loop_q;
    prev_pc_d = prev_pc_q;
    cycle_d   = cycle_q;
    retire_d  = retire_q;
    gp_d      = gp_q;
    if (state_q == S_RESET) begin
      hold_d = hold_q + HOLD_ONE;
    end else if (state_q == S_RUN) begin
      cycle_d   = (cycle_q == CNT_MAX) ? cycle_q : cycle_q + CNT_ONE;
      prev_pc_d = pc_addr;
      loop_d    = pc_same ? loop_q + LOOP_ONE : '0;
      if (we_regs) begin
        retire_d = (retire_q == CNT_MAX) ? retire_q : retire_q + CNT_ONE;
        if (w_regs_addr == 5'd3) gp_d = w_regs_data;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    fail_code_d = fail_code_q;
    case (state_q)
      S_RESET: begin
        if (hold_q == HOLD_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        // A tohost store of 0 is the test clearing the mailbox, not a result.
        if (tohost_hit && (mem_wdata == DATA_ONE)) begin
          state_d  = S_PASS;
          status_d = 2'd1;
        end else if (tohost_hit && (mem_wdata != '0)) begin
          state_d     = S_FAIL;
          status_d    = 2'd1;
          fail_code_d = mem_wdata >> 1;
        end else if (pc_same && (loop_q == LOOP_LAST)) begin
          state_d  = S_HALT;
          status_d = 2'd2;
        end else if (cycle_q == CYC_LAST) begin
          state_d  = S_HALT;
          status_d = 2'd3;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    core_rst     = (state_q != S_RUN);
    running      = (state_q == S_RUN);
    done         = (state_q == S_PASS) || (state_q == S_FAIL) || (state_q == S_HALT);
    pass         = (state_q == S_PASS);
    status       = status_q;
    fail_code    = fail_code_q;
    cycle_count  = cycle_q;
    retire_count = retire_q;
    gp_value     = gp_q;
  end

endmodule
